// File: rtl/systolic_job_scheduler_pkg.sv
// Shared types and constants for the systolic job scheduler and its arbiter.
package systolic_job_scheduler_pkg;

    localparam int unsigned ELEM_W      = 8;
    localparam int unsigned MAT_ELEMS   = 9;
    localparam int unsigned OPND_W      = ELEM_W * MAT_ELEMS;
    localparam int unsigned ID_W        = 2;
    localparam int unsigned JOBS_W      = 16;
    localparam int unsigned DEF_ACC_W   = 20;
    localparam int unsigned DEF_TIMEOUT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Operand pair held on the feeder inputs for the duration of a job.
    typedef struct packed {
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] a;
    } job_t;

    // LSB position of packed element k when every element is w bits wide.
    function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/systolic_job_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module systolic_job_scheduler_rr_arbiter
    import systolic_job_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [ID_W-1:0]    idx_c_o,
    output logic               any_c_o
);

    // Walk the requesters in rotated order; the first hit wins.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!any_c_o && (k == ((32'(ptr_i) + i) % NUM_REQ)) && req_i[k]) begin
                    any_c_o    = 1'b1;
                    gnt_c_o[k] = 1'b1;
                    idx_c_o    = ID_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/systolic_job_scheduler.sv
// Shares one 3x3 systolic feeder/array between NUM_REQ requesters; one job in flight
// at a time, results returned on a tagged response channel with timeout protection.
module systolic_job_scheduler
    import systolic_job_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*OPND_W-1:0]    req_a,
    input  logic [NUM_REQ*OPND_W-1:0]    req_b,
    output logic                         mc_start,
    output logic [OPND_W-1:0]            mc_a,
    output logic [OPND_W-1:0]            mc_b,
    input  logic                         mc_done,
    input  logic [MAT_ELEMS*ACC_W-1:0]   arr_c,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [MAT_ELEMS*ACC_W-1:0]   rsp_data,
    output logic                         rsp_err,
    output logic                         busy,
    output logic                         stray_done,
    output logic [JOBS_W-1:0]            jobs_done
);

    localparam int unsigned RES_W = MAT_ELEMS * ACC_W;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_START = 2'(START);
    localparam logic [1:0] ST_RUN   = 2'(RUN);
    localparam logic [1:0] ST_RESP  = 2'(RESP);

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    job_t              job_q, job_d;
    logic              start_q, start_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [RES_W-1:0]  data_q, data_d;
    logic              err_q, err_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;
    logic              stray_q, stray_d;
    logic [JOBS_W-1:0] jobs_done_q, jobs_done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    job_t               win_job;

    systolic_job_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .gnt_c_o (gnt),
        .idx_c_o (gnt_idx),
        .any_c_o (gnt_any)
    );

    // One-hot operand mux for the granted requester.
    always_comb begin
        win_job = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_job.a = req_a[elem_lsb(i, OPND_W) +: OPND_W];
                win_job.b = req_b[elem_lsb(i, OPND_W) +: OPND_W];
            end
        end
    end

    // Accept only in IDLE; held low while reset is asserted.
    assign req_ready = (reset_n && (state_q == ST_IDLE)) ? gnt : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        job_d       = job_q;
        start_d     = 1'b0;
        id_d        = id_q;
        data_d      = data_q;
        err_d       = err_q;
        rvalid_d    = rvalid_q;
        jobs_done_d = jobs_done_q;
        cnt_d       = cnt_q;
        stray_d     = stray_q | (mc_done && (state_q != ST_RUN));

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    job_d   = win_job;
                    id_d    = gnt_idx;
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done landing on the timeout cycle still counts as success.
                if (mc_done) begin
                    data_d   = arr_c;
                    err_d    = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    data_d   = '0;
                    err_d    = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rvalid_d    = 1'b0;
                    jobs_done_d = jobs_done_q + JOBS_W'(1);
                    ptr_d       = ((32'(id_q) + 32'd1) >= NUM_REQ) ? '0 : id_q + ID_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            job_q       <= '0;
            start_q     <= 1'b0;
            id_q        <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            stray_q     <= 1'b0;
            jobs_done_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            job_q       <= job_d;
            start_q     <= start_d;
            id_q        <= id_d;
            data_q      <= data_d;
            err_q       <= err_d;
            rvalid_q    <= rvalid_d;
            busy_q      <= busy_d;
            stray_q     <= stray_d;
            jobs_done_q <= jobs_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mc_start   = start_q;
    assign mc_a       = job_q.a;
    assign mc_b       = job_q.b;
    assign rsp_valid  = rvalid_q;
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;
    assign busy       = busy_q;
    assign stray_done = stray_q;
    assign jobs_done  = jobs_done_q;

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// Directed bench for systolic_job_scheduler with a nominal-timing feeder model and a
// response scoreboard.
module tb_systolic_job_scheduler;
    import systolic_job_scheduler_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 20;
    localparam int unsigned TO   = 32;
    localparam int unsigned RW   = MAT_ELEMS * AW;
    localparam int unsigned LAT  = 12;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            err;
        logic [RW-1:0]   data;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*OPND_W-1:0]     req_a;
    logic [NREQ*OPND_W-1:0]     req_b;
    logic                       mc_start;
    logic [OPND_W-1:0]          mc_a;
    logic [OPND_W-1:0]          mc_b;
    logic                       mc_done;
    logic [RW-1:0]              arr_c;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [RW-1:0]              rsp_data;
    logic                       rsp_err;
    logic                       busy;
    logic                       stray_done;
    logic [JOBS_W-1:0]          jobs_done;

    logic [OPND_W-1:0] opa [NREQ];
    logic [OPND_W-1:0] opb [NREQ];
    exp_t              sb_q [$];
    int                vectors = 0;
    int                miscompares = 0;
    int unsigned       exp_ptr = 0;
    logic [JOBS_W-1:0] exp_jobs = '0;
    int                starts = 0;
    int                fd_cnt = 0;
    logic              fd_en = 1'b1;
    logic              fd_done = 1'b0;
    logic              stray_pulse = 1'b0;
    logic [OPND_W-1:0] sa, sb;

    assign req_a   = {opa[1], opa[0]};
    assign req_b   = {opb[1], opb[0]};
    assign mc_done = fd_done | stray_pulse;

    systolic_job_scheduler #(
        .NUM_REQ (NREQ),
        .ACC_W   (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mc_start   (mc_start),
        .mc_a       (mc_a),
        .mc_b       (mc_b),
        .mc_done    (mc_done),
        .arr_c      (arr_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .stray_done (stray_done),
        .jobs_done  (jobs_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OPND_W-1:0] mk(input int unsigned base, input int unsigned step);
        logic [OPND_W-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MAT_ELEMS; k++) m[k*ELEM_W +: ELEM_W] = 8'(base + step * k);
        return m;
    endfunction

    // Reference 3x3 unsigned matrix product, row-major, element 0 in the low bits.
    function automatic logic [RW-1:0] matmul(input logic [OPND_W-1:0] a, input logic [OPND_W-1:0] b);
        logic [RW-1:0] c;
        int unsigned   s;
        c = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
                s = 0;
                for (int unsigned k = 0; k < 3; k++)
                    s += 32'(a[(3*i+k)*ELEM_W +: ELEM_W]) * 32'(b[(3*k+j)*ELEM_W +: ELEM_W]);
                c[(3*i+j)*AW +: AW] = AW'(s);
            end
        end
        return c;
    endfunction

    function automatic int unsigned pick(input logic [NREQ-1:0] m, input int unsigned p);
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned k;
            k = (p + i) % NREQ;
            if (m[k]) return k;
        end
        return 0;
    endfunction

    // Feeder model: done 11 cycles after the start pulse, operands must not move meanwhile.
    initial begin
        arr_c = '0;
        forever begin
            @(posedge clk);
            #1;
            fd_done = 1'b0;
            arr_c   = matmul(mc_a, mc_b);
            if (!reset_n) begin
                fd_cnt = 0;
            end else begin
                if (fd_cnt > 0) begin
                    chk("mc_a_hold", RW'(mc_a), RW'(sa));
                    chk("mc_b_hold", RW'(mc_b), RW'(sb));
                    fd_cnt--;
                    if (fd_cnt == 0 && fd_en) fd_done = 1'b1;
                end
                if (mc_start) begin
                    fd_cnt = 11;
                    sa     = mc_a;
                    sb     = mc_b;
                    starts++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_job(input logic [NREQ-1:0] mask, input bit push, input bit exp_err);
        int unsigned     w;
        logic [NREQ-1:0] oh;
        exp_t            e;
        w  = pick(mask, exp_ptr);
        oh = NREQ'(1) << w;
        req_valid = mask;
        #1;
        chk("req_ready_grant", RW'(req_ready), RW'(oh));
        tick();
        chk("mc_start_pulse", RW'(mc_start), RW'(1));
        chk("busy_start", RW'(busy), RW'(1));
        chk("req_ready_start", RW'(req_ready), RW'(0));
        chk("mc_a_route", RW'(mc_a), RW'(opa[w]));
        chk("mc_b_route", RW'(mc_b), RW'(opb[w]));
        if (push) begin
            e.id   = ID_W'(w);
            e.err  = exp_err;
            e.data = exp_err ? '0 : matmul(opa[w], opb[w]);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_rsp(input int exp_lat, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
            chk("req_ready_busy", RW'(req_ready), RW'(0));
            chk("mc_start_low", RW'(mc_start), RW'(0));
        end
        chk("rsp_latency", RW'(n), RW'(exp_lat));
        chk("rsp_valid_rise", RW'(rsp_valid), RW'(1));
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", RW'(rsp_valid), RW'(1));
            chk("hold_id", RW'(rsp_id), RW'(e.id));
            chk("hold_data", rsp_data, e.data);
            chk("hold_ready", RW'(req_ready), RW'(0));
            tick();
        end
        chk("rsp_id", RW'(rsp_id), RW'(e.id));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", RW'(rsp_err), RW'(e.err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_jobs = exp_jobs + JOBS_W'(1);
        exp_ptr  = (32'(e.id) + 1) % NREQ;
        chk("rsp_valid_drop", RW'(rsp_valid), RW'(0));
        chk("jobs_done", RW'(jobs_done), RW'(exp_jobs));
    endtask

    task automatic chk_all_zero(input string phase);
        chk({phase, "_req_ready"}, RW'(req_ready), RW'(0));
        chk({phase, "_mc_start"}, RW'(mc_start), RW'(0));
        chk({phase, "_mc_a"}, RW'(mc_a), RW'(0));
        chk({phase, "_mc_b"}, RW'(mc_b), RW'(0));
        chk({phase, "_rsp_valid"}, RW'(rsp_valid), RW'(0));
        chk({phase, "_rsp_id"}, RW'(rsp_id), RW'(0));
        chk({phase, "_rsp_data"}, rsp_data, RW'(0));
        chk({phase, "_rsp_err"}, RW'(rsp_err), RW'(0));
        chk({phase, "_busy"}, RW'(busy), RW'(0));
        chk({phase, "_stray"}, RW'(stray_done), RW'(0));
        chk({phase, "_jobs"}, RW'(jobs_done), RW'(0));
    endtask

    initial begin
        logic [OPND_W-1:0] ident;
        ident = '0;
        ident[0*ELEM_W +: ELEM_W] = 8'd1;
        ident[4*ELEM_W +: ELEM_W] = 8'd1;
        ident[8*ELEM_W +: ELEM_W] = 8'd1;
        opa[0] = ident;
        opb[0] = mk(2, 0);
        opa[1] = mk(1, 1);
        opb[1] = mk(3, 2);
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Single job: identity x all-2 gives all-2 results.
        send_job(2'b01, 1'b1, 1'b0);
        req_valid = '0;
        chk("all_twos_model", matmul(opa[0], opb[0]), {9{20'd2}});
        wait_rsp(LAT, 0);
        chk("start_count", RW'(starts), RW'(1));

        // Round-robin with both requesters continuously valid.
        for (int j = 0; j < 4; j++) begin
            send_job(2'b11, 1'b1, 1'b0);
            wait_rsp(LAT, 0);
        end
        req_valid = '0;

        // Timeout, then a normal job.
        fd_en = 1'b0;
        send_job(2'b01, 1'b1, 1'b1);
        req_valid = '0;
        wait_rsp(TO + 1, 0);
        fd_en = 1'b1;
        send_job(2'b10, 1'b1, 1'b0);
        req_valid = '0;
        wait_rsp(LAT, 0);

        // Backpressure with competing requests pending.
        opa[0] = mk(5, 3);
        opb[0] = mk(7, 1);
        send_job(2'b01, 1'b1, 1'b0);
        req_valid = 2'b11;
        wait_rsp(LAT, 20);
        req_valid = '0;

        // Stray done in IDLE.
        chk("stray_before", RW'(stray_done), RW'(0));
        stray_pulse = 1'b1;
        tick();
        stray_pulse = 1'b0;
        chk("stray_set", RW'(stray_done), RW'(1));
        chk("stray_busy", RW'(busy), RW'(0));
        chk("stray_no_rsp", RW'(rsp_valid), RW'(0));
        repeat (5) tick();
        chk("stray_sticky", RW'(stray_done), RW'(1));
        chk("stray_no_rsp_later", RW'(rsp_valid), RW'(0));
        chk("stray_jobs", RW'(jobs_done), RW'(exp_jobs));

        // Reset in the middle of RUN.
        send_job(2'b01, 1'b0, 1'b0);
        repeat (4) tick();
        chk("run_busy", RW'(busy), RW'(1));
        req_valid = 2'b01;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_ptr  = 0;
        exp_jobs = '0;
        tick();
        tick();
        req_valid = '0;
        reset_n = 1'b1;
        tick();

        // Completion counter wrap.
        force dut.jobs_done_d = 16'hFFFF;
        tick();
        release dut.jobs_done_d;
        tick();
        chk("jobs_preload", RW'(jobs_done), RW'(16'hFFFF));
        exp_jobs = 16'hFFFF;
        send_job(2'b01, 1'b1, 1'b0);
        req_valid = '0;
        wait_rsp(LAT, 0);
        chk("jobs_wrap", RW'(jobs_done), RW'(0));

        chk("sb_drained", RW'(sb_q.size()), RW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
